ram_arbiter: RTL

Two-requester arbiter and word sequencer in front of the byte-wide single-port RAM. Each requester issues 32-bit (WORD_BYTES x DATA_WIDTH) read or write transactions with byte enables. The block grants requesters round-robin and splits each word into sequential byte beats on the single RAM address/data port. Typical use: requester 0 = instruction fetch, requester 1 = load/store unit.

---
 rtl/ram_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter that serialises word-wide read/write
// transactions into byte beats on a single-port, byte-wide RAM.
module ram_arbiter #(
  parameter  int ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH = 8,
  parameter  int WORD_BYTES = 4,
  localparam int W          = WORD_BYTES * DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // Handshake: a request is accepted in the cycle where valid && ready are
  // both 1; inputs only need to be stable in that cycle. Responses are a
  // single-cycle valid pulse with no backpressure.
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [W-1:0]          i_req0_wdata,
  input  logic [WORD_BYTES-1:0] i_req0_be,
  output logic                  o_rsp0_valid,
  output logic [W-1:0]          o_rsp0_rdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [W-1:0]          i_req1_wdata,
  input  logic [WORD_BYTES-1:0] i_req1_be,
  output logic                  o_rsp1_valid,
  output logic [W-1:0]          o_rsp1_rdata,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic [1:0]            o_state
);

  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORD_BYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BEAT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic [BW-1:0]         beat;
  logic                  owner;
  logic                  last_grant;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [W-1:0]          wdata_q;
  logic [WORD_BYTES-1:0] be_q;
  logic [W-1:0]          rdata_q;

  logic sel0, sel1, in_idle, in_beat, in_resp;

  assign in_idle = (state == ST_IDLE);
  assign in_beat = (state == ST_BEAT);
  assign in_resp = (state == ST_RESP);

  // On a tie the requester that did not win last time is chosen.
  assign sel0 = i_req0_valid && (!i_req1_valid || last_grant);
  assign sel1 = i_req1_valid && (!i_req0_valid || !last_grant);

  assign o_req0_ready = in_idle && sel0;
  assign o_req1_ready = in_idle && sel1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      beat       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (o_req0_ready || o_req1_ready) begin
            owner      <= o_req1_ready;
            last_grant <= o_req1_ready;
            we_q       <= o_req1_ready ? i_req1_we    : i_req0_we;
            addr_q     <= o_req1_ready ? i_req1_addr  : i_req0_addr;
            wdata_q    <= o_req1_ready ? i_req1_wdata : i_req0_wdata;
            be_q       <= o_req1_ready ? i_req1_be    : i_req0_be;
            rdata_q    <= '0;
            beat       <= '0;
            state      <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          // Writes leave rdata_q cleared so their response word is zero.
          if (!we_q) rdata_q[beat*DATA_WIDTH +: DATA_WIDTH] <= i_ram_rdata;
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= ST_RESP;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ram_we    = in_beat && we_q && be_q[beat];
  assign o_ram_addr  = in_beat ? (addr_q + ADDR_WIDTH'(beat)) : '0;
  assign o_ram_wdata = in_beat ? wdata_q[beat*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign o_rsp0_valid = in_resp && !owner;
  assign o_rsp1_valid = in_resp &&  owner;
  assign o_rsp0_rdata = o_rsp0_valid ? rdata_q : '0;
  assign o_rsp1_rdata = o_rsp1_valid ? rdata_q : '0;

  assign o_state = state;

endmodule
